// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, default
// memory widths and the index-width helper used by the arbiter and picker.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  // Bits needed to hold a requester index; never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request bit searching
// upward from last_i+1, wrapping modulo NUM_REQ.
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  // NOTE: every variable gets a default before the loop so no path through
  // this block leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req_i[pos_idx]) begin
        found   = 1'b1;
        grant_o = pos_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters;
// each transaction runs SETUP -> STROBE -> HOLD with all outputs registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         to_mem,
  output logic                      mem_write,
  output logic                      mem_clock,
  input  logic [DATA_W-1:0]         from_mem
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   last_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [NUM_REQ-1:0] done_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               busy_q;
  logic [ADDR_W-1:0]  address_q;
  logic [DATA_W-1:0]  to_mem_q;
  logic               mem_write_q;
  logic               mem_clock_q;

  logic [IDX_W-1:0]   pick_idx_d;
  logic               pick_valid_d;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr[NUM_REQ];

  // Unpack the flat request buses so only real requester slots are indexable.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_idx_d),
    .valid_o (pick_valid_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      address_q   <= '0;
      to_mem_q    <= '0;
      mem_write_q <= 1'b0;
      mem_clock_q <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          mem_write_q <= 1'b0;
          mem_clock_q <= 1'b0;
          if (pick_valid_d) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            grant_q <= pick_idx_d;
            last_q  <= pick_idx_d;
            we_q    <= req_we[pick_idx_d];
            addr_q  <= addr_arr[pick_idx_d];
            wdata_q <= wdata_arr[pick_idx_d];
          end
        end
        ST_SETUP: begin
          address_q   <= addr_q;
          to_mem_q    <= wdata_q;
          mem_write_q <= we_q;
          mem_clock_q <= 1'b0;
          state_q     <= ST_STROBE;
        end
        ST_STROBE: begin
          mem_clock_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          // from_mem has settled a full cycle after the strobe edge.
          mem_clock_q     <= 1'b0;
          if (!we_q) rdata_q <= from_mem;
          done_q[grant_q] <= 1'b1;
          busy_q          <= 1'b0;
          state_q         <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign address   = address_q;
  assign to_mem    = to_mem_q;
  assign mem_write = mem_write_q;
  assign mem_clock = mem_clock_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256x8 behavioural memory that
// writes on the rising edge of mem_clock and reads combinationally.
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         address;
  logic [DATA_W-1:0]         to_mem;
  logic                      mem_write;
  logic                      mem_clock;
  logic [DATA_W-1:0]         from_mem;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .address   (address),
    .to_mem    (to_mem),
    .mem_write (mem_write),
    .mem_clock (mem_clock),
    .from_mem  (from_mem)
  );

  always #5 clock = ~clock;

  assign from_mem = mem[address];

  always @(posedge mem_clock) begin
    if (mem_write) mem[address] <= to_mem;
  end

  // Strobe hygiene: never high two samples running, and address/mem_write
  // never move while it is high.
  logic       mc_prev = 1'b0;
  logic [7:0] addr_prev = '0;
  logic       we_prev = 1'b0;
  always @(negedge clock) begin
    if (mem_clock) begin
      checks++;
      if (mc_prev || address !== addr_prev || mem_write !== we_prev) begin
        failures++;
        $display("FAIL strobe_hygiene mc_prev=%b addr=%h prev_addr=%h we=%b prev_we=%b",
                 mc_prev, address, addr_prev, mem_write, we_prev);
      end
    end
    mc_prev   <= mem_clock;
    addr_prev <= address;
    we_prev   <= mem_write;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    checks++; if (done !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl done=%b busy=%b exp done=000 busy=0", done, busy); end
    checks++; if (address !== 8'h00 || to_mem !== 8'h00 || rdata !== 8'h00) begin failures++; $display("FAIL reset_data addr=%h to_mem=%h rdata=%h exp all 00", address, to_mem, rdata); end
    checks++; if (mem_clock !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL reset_strobe mc=%b mw=%b exp 0 0", mem_clock, mem_write); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp 0", busy); end
  endtask

  task automatic test_single_read();
    req_addr[0*ADDR_W +: ADDR_W] = 8'h10;
    req = 3'b001;
    tick(); // edge 0
    checks++; if (busy !== 1'b1 || mem_clock !== 1'b0) begin failures++; $display("FAIL rd_e0 busy=%b mc=%b exp 1 0", busy, mem_clock); end
    tick(); // edge 1
    checks++; if (address !== 8'h10 || mem_clock !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rd_e1 addr=%h mc=%b mw=%b exp 10 0 0", address, mem_clock, mem_write); end
    tick(); // edge 2
    checks++; if (mem_clock !== 1'b1 || mem_write !== 1'b0 || done !== 3'b000) begin failures++; $display("FAIL rd_e2 mc=%b mw=%b done=%b exp 1 0 000", mem_clock, mem_write, done); end
    tick(); // edge 3
    checks++; if (done !== 3'b001 || rdata !== 8'hA5 || mem_clock !== 1'b0) begin failures++; $display("FAIL rd_e3 done=%b rdata=%h mc=%b exp 001 a5 0", done, rdata, mem_clock); end
    req = 3'b000;
    tick();
    checks++; if (done !== 3'b000 || busy !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rd_e4 done=%b busy=%b mw=%b exp 000 0 0", done, busy, mem_write); end
  endtask

  task automatic test_write();
    req_we[1] = 1'b1;
    req_addr[1*ADDR_W +: ADDR_W]  = 8'h20;
    req_wdata[1*DATA_W +: DATA_W] = 8'h3C;
    req = 3'b010;
    tick(); tick(); // edges 0,1
    checks++; if (mem_write !== 1'b1 || to_mem !== 8'h3C || address !== 8'h20 || mem_clock !== 1'b0) begin failures++; $display("FAIL wr_e1 mw=%b to_mem=%h addr=%h mc=%b exp 1 3c 20 0", mem_write, to_mem, address, mem_clock); end
    tick(); // edge 2
    checks++; if (mem_clock !== 1'b1 || mem_write !== 1'b1 || to_mem !== 8'h3C) begin failures++; $display("FAIL wr_e2 mc=%b mw=%b to_mem=%h exp 1 1 3c", mem_clock, mem_write, to_mem); end
    tick(); // edge 3
    checks++; if (done !== 3'b010 || rdata !== 8'hA5 || mem_write !== 1'b1) begin failures++; $display("FAIL wr_e3 done=%b rdata=%h mw=%b exp 010 a5 1", done, rdata, mem_write); end
    checks++; if (mem[8'h20] !== 8'h3C) begin failures++; $display("FAIL wr_mem got=%h exp 3c", mem[8'h20]); end
    req = 3'b000;
    req_we[1] = 1'b0;
    tick();
    checks++; if (mem_write !== 1'b0 || address !== 8'h20 || done !== 3'b000) begin failures++; $display("FAIL wr_idle mw=%b addr=%h done=%b exp 0 20 000", mem_write, address, done); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_data [3];
    logic [2:0] exp_done;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_addr = {8'h32, 8'h31, 8'h30};
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp_done = 3'b001 << (t % 3);
      for (int e = 0; e < 4; e++) begin
        tick();
        if (e < 3) begin
          checks++; if (done !== 3'b000) begin failures++; $display("FAIL cont_quiet t=%0d e=%0d done=%b exp 000", t, e, done); end
        end else begin
          checks++; if (done !== exp_done || rdata !== exp_data[t % 3]) begin failures++; $display("FAIL cont_grant t=%0d done=%b rdata=%h exp %b %h", t, done, rdata, exp_done, exp_data[t % 3]); end
        end
      end
    end
    req = 3'b000;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_end busy=%b exp 0", busy); end
  endtask

  task automatic test_rotation();
    req = 3'b010; // leaves last=1
    tick(); tick(); tick(); tick();
    checks++; if (done !== 3'b010 || rdata !== 8'h22) begin failures++; $display("FAIL rot_setup done=%b rdata=%h exp 010 22", done, rdata); end
    req = 3'b011;
    tick(); tick(); tick(); tick();
    checks++; if (done !== 3'b001 || rdata !== 8'h11) begin failures++; $display("FAIL rot_first done=%b rdata=%h exp 001 11", done, rdata); end
    tick(); tick(); tick(); tick();
    checks++; if (done !== 3'b010 || rdata !== 8'h22) begin failures++; $display("FAIL rot_second done=%b rdata=%h exp 010 22", done, rdata); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_midop();
    req_addr[0*ADDR_W +: ADDR_W] = 8'h10;
    req = 3'b001;
    tick(); tick(); // now in the STROBE cycle
    checks++; if (busy !== 1'b1 || mem_clock !== 1'b0) begin failures++; $display("FAIL mid_pre busy=%b mc=%b exp 1 0", busy, mem_clock); end
    reset = 1'b1;
    tick();
    checks++; if (mem_clock !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0 || done !== 3'b000) begin failures++; $display("FAIL mid_reset mc=%b mw=%b busy=%b done=%b exp 0 0 0 000", mem_clock, mem_write, busy, done); end
    reset = 1'b0;
    req = 3'b011; // requester 0 wins only if last was reset
    tick(); tick(); tick();
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL mid_nodone done=%b exp 000", done); end
    tick();
    checks++; if (done !== 3'b001 || rdata !== 8'hA5) begin failures++; $display("FAIL mid_fresh done=%b rdata=%h exp 001 a5", done, rdata); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_req_drop();
    req_addr[2*ADDR_W +: ADDR_W] = 8'h40;
    req = 3'b100;
    tick(); // edge 0
    req = 3'b000;
    tick(); tick();
    checks++; if (done !== 3'b000 || busy !== 1'b1) begin failures++; $display("FAIL drop_mid done=%b busy=%b exp 000 1", done, busy); end
    tick(); // edge 3
    checks++; if (done !== 3'b100 || rdata !== 8'h5A) begin failures++; $display("FAIL drop_done done=%b rdata=%h exp 100 5a", done, rdata); end
    tick();
    checks++; if (done !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL drop_after done=%b busy=%b exp 000 0", done, busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h11;
    mem[8'h31] = 8'h22;
    mem[8'h32] = 8'h33;
    mem[8'h40] = 8'h5A;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_rotation();
    test_reset_midop();
    test_req_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
